// File: rtl/cat_seq_pkg.sv
// Shared types and constants for the cat-recognizer sequencer.
// Optional interrupt output is enabled with the CAT_SEQ_IRQ_EN macro.
package cat_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_RESULT,
    ST_CAPTURE
  } state_t;

  // Register offsets inside the four-word window at the top of the address map
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_LEN    = 2'd2;
  localparam logic [1:0] OFF_BIAS   = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_IRQ_MASK = 2;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_RESULT = 2;

  function automatic int unsigned reg_base(input int unsigned addr_width);
    return (32'd1 << addr_width) - 32'd4;
  endfunction

endpackage

// File: rtl/cat_seq_if.sv
// APB slave bus bundle for the cat-recognizer sequencer.
interface cat_seq_if #(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 12
);

  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [Amba_Addr_Depth-1:0] PADDR;
  logic [Amba_Word-1:0]       PWDATA;
  logic [Amba_Word-1:0]       PRDATA;
  logic                       PREADY;
  logic                       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/cat_seq_delay_line.sv
// Fixed-depth 1-bit shift register with synchronous flush; aligns the
// accumulate strobe with data returning from the pixel/weight memories.
module cat_seq_delay_line #(
  parameter int Depth = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [Depth-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else if (flush) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < Depth; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign dout = pipe[Depth-1];

endmodule

// File: rtl/cat_seq_controller.sv
// Inference sequencer: APB register window, pixel write gating and the
// memory walk FSM. Define CAT_SEQ_IRQ_EN to add the irq output.
module cat_seq_controller
  import cat_seq_pkg::*;
#(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 12,
  parameter int Mem_Latency     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  cat_seq_if.slave                   apb,
  output logic [Amba_Addr_Depth-1:0] mem_addr,
  output logic                       mem_wr_en,
  output logic                       mem_rd_en,
  output logic                       calc_clear,
  output logic                       calc_enable,
  output logic                       calc_get_result,
  output logic [Amba_Word-1:0]       bias,
  input  logic                       cat_result
`ifdef CAT_SEQ_IRQ_EN
  ,
  output logic                       irq
`endif
);

  localparam logic [Amba_Addr_Depth-1:0] REG_BASE =
    Amba_Addr_Depth'(reg_base(Amba_Addr_Depth));
  localparam logic [Amba_Addr_Depth-1:0] ADDR_ONE = Amba_Addr_Depth'(1);
  localparam logic [2:0] DRAIN_LAST = 3'(Mem_Latency - 1);

  state_t                     state;
  state_t                     state_nxt;
  logic [Amba_Addr_Depth-1:0] len_q;
  logic [Amba_Addr_Depth-1:0] walk_cnt;
  logic [Amba_Word-1:0]       bias_q;
  logic [Amba_Word-1:0]       rd_data;
  logic [2:0]                 drain_cnt;
  logic                       stat_done;
  logic                       stat_result;
  logic                       busy;
  logic                       wr_commit;
  logic                       below_base;
  logic                       ctrl_wr;
  logic                       start_cmd;
  logic                       abort_cmd;
  logic                       reject;
  logic                       rd_en_int;
  logic [1:0]                 reg_off;
`ifdef CAT_SEQ_IRQ_EN
  logic                       irq_mask;
`endif

  assign busy       = (state != ST_IDLE);
  assign wr_commit  = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign below_base = (apb.PADDR < REG_BASE);
  assign reg_off    = apb.PADDR[1:0];
  assign ctrl_wr    = wr_commit & ~below_base & (reg_off == OFF_CTRL);

  // Abort outranks a start carried in the same CTRL write
  assign abort_cmd = ctrl_wr & apb.PWDATA[CTRL_ABORT] & busy;
  assign start_cmd = ctrl_wr & apb.PWDATA[CTRL_START] & ~apb.PWDATA[CTRL_ABORT] & ~busy;

  assign reject = wr_commit & busy &
                  (below_base | (reg_off == OFF_LEN) | (reg_off == OFF_BIAS));

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = reject;
  assign apb.PRDATA  = rd_data;

  assign mem_wr_en = wr_commit & below_base & ~busy;
  assign mem_rd_en = rd_en_int;
  assign mem_addr  = busy ? walk_cnt : apb.PADDR;
  assign bias      = bias_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    calc_clear      = 1'b0;
    rd_en_int       = 1'b0;
    calc_get_result = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_cmd) state_nxt = ST_CLEAR;
      end
      // A zero-length walk still waits out the drain so result timing is uniform
      ST_CLEAR: begin
        calc_clear = 1'b1;
        state_nxt  = (len_q == '0) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        rd_en_int = 1'b1;
        if (walk_cnt == len_q - ADDR_ONE) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = ST_RESULT;
      end
      ST_RESULT: begin
        calc_get_result = 1'b1;
        state_nxt       = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (abort_cmd) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      walk_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      walk_cnt  <= (state == ST_RUN)   ? walk_cnt + ADDR_ONE : '0;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 3'd1    : '0;
    end
  end

  // LEN is clamped so the walk counter can never reach the register window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      bias_q      <= '0;
      stat_done   <= 1'b0;
      stat_result <= 1'b0;
    end else begin
      if (wr_commit && !below_base && !busy && reg_off == OFF_LEN) begin
        len_q <= (apb.PWDATA > Amba_Word'(REG_BASE)) ? REG_BASE
                                                     : apb.PWDATA[Amba_Addr_Depth-1:0];
      end
      if (wr_commit && !below_base && !busy && reg_off == OFF_BIAS) begin
        bias_q <= apb.PWDATA;
      end
      if (start_cmd) begin
        stat_done <= 1'b0;
      end else if (state == ST_CAPTURE && !abort_cmd) begin
        stat_done   <= 1'b1;
        stat_result <= cat_result;
      end
    end
  end

`ifdef CAT_SEQ_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_mask <= 1'b0;
    end else if (ctrl_wr) begin
      irq_mask <= apb.PWDATA[CTRL_IRQ_MASK];
    end
  end

  assign irq = stat_done & irq_mask;
`endif

  always_comb begin
    rd_data = '0;
    if (apb.PSEL && !below_base) begin
      unique case (reg_off)
        OFF_CTRL: begin
`ifdef CAT_SEQ_IRQ_EN
          rd_data[CTRL_IRQ_MASK] = irq_mask;
`else
          rd_data = '0;
`endif
        end
        OFF_STATUS: begin
          rd_data[STAT_BUSY]   = busy;
          rd_data[STAT_DONE]   = stat_done;
          rd_data[STAT_RESULT] = stat_result;
        end
        OFF_LEN: begin
          rd_data[Amba_Addr_Depth-1:0] = len_q;
        end
        OFF_BIAS: begin
          rd_data = bias_q;
        end
        default: begin
          rd_data = '0;
        end
      endcase
    end
  end

  cat_seq_delay_line #(
    .Depth (Mem_Latency)
  ) u_delay_line (
    .clk   (clk),
    .rst   (rst),
    .flush (abort_cmd),
    .din   (rd_en_int),
    .dout  (calc_enable)
  );

endmodule

// File: tb/tb_cat_seq_controller.sv
// Self-checking bench for cat_seq_controller: randomized walks against a
// cycle-schedule reference model derived from the sequencer timing rules.
module tb_cat_seq_controller;

  localparam int AW = 12;
  localparam int W  = 24;
  localparam int ML = 1;
  localparam logic [AW-1:0] REG_BASE = 12'((1 << AW) - 4);
  localparam logic [AW-1:0] A_CTRL   = REG_BASE;
  localparam logic [AW-1:0] A_STATUS = REG_BASE + 12'd1;
  localparam logic [AW-1:0] A_LEN    = REG_BASE + 12'd2;
  localparam logic [AW-1:0] A_BIAS   = REG_BASE + 12'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic          calc_clear;
  logic          calc_enable;
  logic          calc_get_result;
  logic [W-1:0]  bias;
  logic          cat_result = 1'b0;
`ifdef CAT_SEQ_IRQ_EN
  logic          irq;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  int           m_len    = 0;
  logic [W-1:0] m_bias   = '0;
  logic         m_done   = 1'b0;
  logic         m_result = 1'b0;
  logic         m_mask   = 1'b0;

  cat_seq_if #(.Amba_Word(W), .Amba_Addr_Depth(AW)) apb ();

  cat_seq_controller #(
    .Amba_Word       (W),
    .Amba_Addr_Depth (AW),
    .Mem_Latency     (ML)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .apb             (apb),
    .mem_addr        (mem_addr),
    .mem_wr_en       (mem_wr_en),
    .mem_rd_en       (mem_rd_en),
    .calc_clear      (calc_clear),
    .calc_enable     (calc_enable),
    .calc_get_result (calc_get_result),
    .bias            (bias),
    .cat_result      (cat_result)
`ifdef CAT_SEQ_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int sat_len(input int v);
    return (v > int'(REG_BASE)) ? int'(REG_BASE) : v;
  endfunction

  task automatic apb_write(input logic [AW-1:0] a, input logic [W-1:0] d,
                           output logic err, output logic wr, output logic [AW-1:0] maddr);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = d;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    @(negedge clk);
    err = apb.PSLVERR; wr = mem_wr_en; maddr = mem_addr;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [W-1:0] d);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = a;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    @(negedge clk);
    d = apb.PRDATA;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PADDR = '0;
  endtask

  task automatic wait_idle();
    logic [W-1:0] d;
    int n;
    n = 0;
    do begin
      apb_read(A_STATUS, d);
      n++;
    end while (d[0] && n < 100);
    total_cnt++;
    if (d[0] !== 1'b0) $display("[TB] FAIL idle_wait: busy=%b after %0d polls, required 0", d[0], n);
    else pass_cnt++;
  endtask

  // Starts a walk and checks every cycle against the expected schedule
  task automatic run_walk(input int len_val, input logic cat_val, input logic mask_val);
    logic err, wr;
    logic [AW-1:0] ma;
    logic [3:0] exp_strb, act_strb;
    logic [W-1:0] exp_stat;
    int last;
    cat_result = cat_val;
    apb_write(A_LEN, W'(len_val), err, wr, ma);
    m_len = sat_len(len_val);
    apb_write(A_CTRL, {21'd0, mask_val, 1'b0, 1'b1}, err, wr, ma);
`ifdef CAT_SEQ_IRQ_EN
    m_mask = mask_val;
`endif
    m_done = 1'b0;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = A_STATUS;
    last = m_len + 4 + ML;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      exp_strb = {c == 1,
                  c >= 2 && c <= 1 + m_len,
                  c >= 2 + ML && c <= 1 + m_len + ML,
                  c == m_len + 2 + ML};
      act_strb = {calc_clear, mem_rd_en, calc_enable, calc_get_result};
      total_cnt++;
      if (act_strb !== exp_strb)
        $display("[TB] FAIL strobes len=%0d cycle=%0d: got %b required %b", m_len, c, act_strb, exp_strb);
      else pass_cnt++;
      if (exp_strb[2]) begin
        total_cnt++;
        if (mem_addr !== AW'(c - 2))
          $display("[TB] FAIL walk_addr cycle=%0d: got %0d required %0d", c, mem_addr, c - 2);
        else pass_cnt++;
      end
      if (c == last) begin
        m_done   = 1'b1;
        m_result = cat_val;
      end
      exp_stat = {21'd0, m_result, m_done, c < last};
      total_cnt++;
      if (apb.PRDATA !== exp_stat)
        $display("[TB] FAIL status len=%0d cycle=%0d: got %b required %b", m_len, c, apb.PRDATA[2:0], exp_stat[2:0]);
      else pass_cnt++;
`ifdef CAT_SEQ_IRQ_EN
      total_cnt++;
      if (irq !== (m_done & m_mask))
        $display("[TB] FAIL irq cycle=%0d: got %b required %b", c, irq, m_done & m_mask);
      else pass_cnt++;
`endif
    end
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PADDR = '0;
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({calc_clear, mem_rd_en, calc_enable, calc_get_result, mem_wr_en, apb.PSLVERR} !== 6'b0)
      $display("[TB] FAIL reset_strobes: got %b required 000000",
               {calc_clear, mem_rd_en, calc_enable, calc_get_result, mem_wr_en, apb.PSLVERR});
    else pass_cnt++;
    total_cnt++;
    if (apb.PREADY !== 1'b1) $display("[TB] FAIL reset_pready: got %b required 1", apb.PREADY);
    else pass_cnt++;
    total_cnt++;
    if (bias !== '0 || mem_addr !== '0 || apb.PRDATA !== '0)
      $display("[TB] FAIL reset_buses: bias=%0h addr=%0h prdata=%0h required 0", bias, mem_addr, apb.PRDATA);
    else pass_cnt++;
`ifdef CAT_SEQ_IRQ_EN
    total_cnt++;
    if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b required 0", irq);
    else pass_cnt++;
`endif
    rst = 1'b0;
    apb_read(A_STATUS, d);
    total_cnt++;
    if (d !== '0) $display("[TB] FAIL reset_status: got %0h required 0", d);
    else pass_cnt++;
    apb_read(A_LEN, d);
    total_cnt++;
    if (d !== '0) $display("[TB] FAIL reset_len: got %0h required 0", d);
    else pass_cnt++;
    apb_read(A_BIAS, d);
    total_cnt++;
    if (d !== '0) $display("[TB] FAIL reset_bias: got %0h required 0", d);
    else pass_cnt++;
  endtask

  task automatic test_registers();
    logic err, wr;
    logic [AW-1:0] ma;
    logic [W-1:0] d, lv, bv;
    for (int i = 0; i < 4; i++) begin
      lv = (i == 0) ? 24'hFFF : (i == 1) ? 24'd4091 : W'($urandom);
      bv = W'($urandom);
      apb_write(A_LEN, lv, err, wr, ma);
      m_len = sat_len(int'(lv));
      apb_write(A_BIAS, bv, err, wr, ma);
      m_bias = bv;
      apb_read(A_LEN, d);
      total_cnt++;
      if (d !== W'(m_len)) $display("[TB] FAIL len_readback wrote=%0h: got %0d required %0d", lv, d, m_len);
      else pass_cnt++;
      apb_read(A_BIAS, d);
      total_cnt++;
      if (d !== m_bias || bias !== m_bias)
        $display("[TB] FAIL bias_readback: reg=%0h port=%0h required %0h", d, bias, m_bias);
      else pass_cnt++;
    end
  endtask

  task automatic test_walk();
    logic err, wr;
    logic [AW-1:0] ma;
    apb_write(A_BIAS, 24'd7, err, wr, ma);
    m_bias = 24'd7;
    run_walk(4, 1'b1, m_mask);
    for (int i = 0; i < 3; i++) begin
      run_walk($urandom_range(1, 12), 1'($urandom_range(0, 1)), m_mask);
    end
    total_cnt++;
    if (bias !== m_bias) $display("[TB] FAIL bias_port: got %0h required %0h", bias, m_bias);
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    run_walk(0, 1'($urandom_range(0, 1)), m_mask);
    run_walk(0, ~m_result, m_mask);
  endtask

  task automatic test_busy_write();
    logic err, wr;
    logic [AW-1:0] ma;
    logic [W-1:0] d;
    cat_result = 1'b0;
    apb_write(A_LEN, 24'd10, err, wr, ma);
    m_len = 10;
    apb_write(A_CTRL, {21'd0, m_mask, 2'b01}, err, wr, ma);
    m_done = 1'b0;
    apb_write(12'd5, W'($urandom), err, wr, ma);
    total_cnt++;
    if (err !== 1'b1 || wr !== 1'b0)
      $display("[TB] FAIL busy_pixel_write: pslverr=%b wr_en=%b required 1/0", err, wr);
    else pass_cnt++;
    apb_write(A_LEN, 24'd3, err, wr, ma);
    total_cnt++;
    if (err !== 1'b1) $display("[TB] FAIL busy_len_write: pslverr=%b required 1", err);
    else pass_cnt++;
    apb_write(A_BIAS, 24'h123456, err, wr, ma);
    total_cnt++;
    if (err !== 1'b1) $display("[TB] FAIL busy_bias_write: pslverr=%b required 1", err);
    else pass_cnt++;
    wait_idle();
    m_done = 1'b1;
    m_result = 1'b0;
    apb_read(A_LEN, d);
    total_cnt++;
    if (d !== W'(m_len)) $display("[TB] FAIL len_after_reject: got %0d required %0d", d, m_len);
    else pass_cnt++;
    apb_read(A_BIAS, d);
    total_cnt++;
    if (d !== m_bias) $display("[TB] FAIL bias_after_reject: got %0h required %0h", d, m_bias);
    else pass_cnt++;
    apb_write(12'd5, W'($urandom), err, wr, ma);
    total_cnt++;
    if (err !== 1'b0 || wr !== 1'b1 || ma !== 12'd5)
      $display("[TB] FAIL idle_pixel_write: pslverr=%b wr_en=%b addr=%0d required 0/1/5", err, wr, ma);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic err, wr;
    logic [AW-1:0] ma;
    logic [W-1:0] d;
    apb_write(A_LEN, 24'd10, err, wr, ma);
    m_len = 10;
    apb_write(A_CTRL, {21'd0, m_mask, 2'b01}, err, wr, ma);
    m_done = 1'b0;
    @(posedge clk);
    apb_write(A_CTRL, {21'd0, m_mask, 2'b11}, err, wr, ma);
    total_cnt++;
    if (ma !== 12'd2) $display("[TB] FAIL abort_point_addr: got %0d required 2", ma);
    else pass_cnt++;
    apb.PSEL = 1'b1; apb.PADDR = A_STATUS;
    @(negedge clk);
    total_cnt++;
    if ({calc_clear, mem_rd_en, calc_enable, calc_get_result} !== 4'b0)
      $display("[TB] FAIL abort_strobes: got %b required 0000",
               {calc_clear, mem_rd_en, calc_enable, calc_get_result});
    else pass_cnt++;
    total_cnt++;
    if (apb.PRDATA !== {21'd0, m_result, 2'b00})
      $display("[TB] FAIL abort_status: got %b required %b", apb.PRDATA[2:0], {m_result, 2'b00});
    else pass_cnt++;
    apb.PSEL = 1'b0; apb.PADDR = '0;
    apb_read(A_STATUS, d);
    total_cnt++;
    if (d !== {21'd0, m_result, 2'b00}) $display("[TB] FAIL abort_idle: got %b required %b", d[2:0], {m_result, 2'b00});
    else pass_cnt++;
    run_walk(10, 1'($urandom_range(0, 1)), m_mask);
  endtask

  task automatic test_irq_mask();
    logic err, wr;
    logic [AW-1:0] ma;
    logic [W-1:0] d;
`ifdef CAT_SEQ_IRQ_EN
    run_walk(3, 1'b1, 1'b1);
    apb_read(A_CTRL, d);
    total_cnt++;
    if (d !== 24'h4) $display("[TB] FAIL ctrl_mask_read: got %0h required 4", d);
    else pass_cnt++;
    run_walk(2, 1'b0, 1'b1);
    apb_write(A_CTRL, 24'h0, err, wr, ma);
    m_mask = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (irq !== 1'b0) $display("[TB] FAIL irq_mask_clear: got %b required 0", irq);
    else pass_cnt++;
`else
    apb_write(A_CTRL, 24'h4, err, wr, ma);
    apb_read(A_CTRL, d);
    total_cnt++;
    if (d !== 24'h0) $display("[TB] FAIL ctrl_mask_absent: got %0h required 0", d);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_walk();
    logic err, wr;
    logic [AW-1:0] ma;
    logic [W-1:0] d;
    apb_write(A_LEN, 24'd8, err, wr, ma);
    m_len = 8;
    apb_write(A_CTRL, {21'd0, m_mask, 2'b01}, err, wr, ma);
    apb.PSEL = 1'b1; apb.PADDR = A_STATUS;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total_cnt++;
    if ({calc_clear, mem_rd_en, calc_enable, calc_get_result} !== 4'b0)
      $display("[TB] FAIL midwalk_reset_strobes: got %b required 0000",
               {calc_clear, mem_rd_en, calc_enable, calc_get_result});
    else pass_cnt++;
    total_cnt++;
    if (apb.PRDATA !== '0 || bias !== '0)
      $display("[TB] FAIL midwalk_reset_regs: status=%0h bias=%0h required 0", apb.PRDATA, bias);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    apb.PSEL = 1'b0; apb.PADDR = '0;
    m_len = 0; m_bias = '0; m_done = 1'b0; m_result = 1'b0; m_mask = 1'b0;
    apb_read(A_LEN, d);
    total_cnt++;
    if (d !== W'(m_len)) $display("[TB] FAIL midwalk_reset_len: got %0d required 0", d);
    else pass_cnt++;
  endtask

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;
    $display("[TB] starting cat_seq_controller bench");
    test_reset();
    test_registers();
    test_walk();
    test_zero_len();
    test_busy_write();
    test_abort();
    test_irq_mask();
    test_reset_mid_walk();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
